// File: rtl/gpio_bidir_filt_if.sv
// Control and status bundle for gpio_bidir_filt.
// Covers pin routing, drive configuration, filter configuration, and the filtered inputs and edge flags.
interface gpio_bidir_filt_if #(
  parameter int IOWidth      = 36,
  parameter int PortNumWidth = 8,
  parameter int FiltWidth    = 4
);
  logic [PortNumWidth-1:0] portselnum [IOWidth];
  logic [IOWidth-1:0]      out_ena;
  logic [IOWidth-1:0]      od;
  logic [IOWidth-1:0]      out_data;
  logic [IOWidth-1:0]      filt_ena;
  logic [FiltWidth-1:0]    filt_len;
  logic [IOWidth-1:0]      flag_clr;
  logic [IOWidth-1:0]      data_from_gpio;
  logic [IOWidth-1:0]      rise_flag;
  logic [IOWidth-1:0]      fall_flag;

  modport master (
    output portselnum, out_ena, od, out_data, filt_ena, filt_len, flag_clr,
    input  data_from_gpio, rise_flag, fall_flag
  );

  modport slave (
    input  portselnum, out_ena, od, out_data, filt_ena, filt_len, flag_clr,
    output data_from_gpio, rise_flag, fall_flag
  );
endinterface

// File: rtl/gpio_bidir_filt.sv
// Bidirectional GPIO block with per-channel pin muxing and a two-flop input synchroniser.
// Each channel also has a glitch filter and sticky rise/fall flags.
module gpio_bidir_filt #(
  parameter int IOWidth      = 36,
  parameter int PortNumWidth = 8,
  parameter int Mux_En       = 1,
  parameter int FiltWidth    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  gpio_bidir_filt_if.slave   bus,
  inout  wire  [IOWidth-1:0] gpioport
);

  localparam logic [FiltWidth-1:0] LenOne = FiltWidth'(1);

  for (genvar i = 0; i < IOWidth; i++) begin : g_ch
    logic [PortNumWidth-1:0] psel;
    logic [31:0]             sel;
    logic                    in_bit;
    logic                    out_bit;
    logic                    bypass;
    logic                    omux;
    logic                    s1;
    logic                    s2;
    logic                    filt;
    logic                    filt_d;
    logic                    rise;
    logic                    fall;
    logic [FiltWidth-1:0]    cnt;

    assign psel = bus.portselnum[i];
    assign sel  = (Mux_En != 0) ? 32'(psel) : 32'(i);

    // A select that matches no pin leaves both mux paths at 0.
    always_comb begin
      in_bit  = 1'b0;
      out_bit = 1'b0;
      for (int j = 0; j < IOWidth; j++) begin
        if (sel == 32'(j)) begin
          in_bit  = gpioport[j];
          out_bit = bus.out_data[j];
        end
      end
    end

    assign gpioport[i] = !bus.out_ena[i] ? 1'bz :
                         bus.od[i]       ? (omux ? 1'b0 : 1'bz) :
                                           omux;

    assign bypass = !bus.filt_ena[i] || (bus.filt_len <= LenOne);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        omux   <= 1'b0;
        s1     <= 1'b0;
        s2     <= 1'b0;
        filt   <= 1'b0;
        filt_d <= 1'b0;
        cnt    <= '0;
        rise   <= 1'b0;
        fall   <= 1'b0;
      end else begin
        omux   <= out_bit;
        s1     <= in_bit;
        s2     <= s1;
        filt_d <= filt;

        if (bypass) begin
          filt <= s2;
          cnt  <= '0;
        end else if (s2 == filt) begin
          cnt <= '0;
        end else if (cnt >= bus.filt_len - LenOne) begin
          // Using >= lets a shortened filt_len take effect at once instead of waiting for a wrap.
          filt <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + LenOne;
        end

        if (filt && !filt_d)     rise <= 1'b1;
        else if (bus.flag_clr[i]) rise <= 1'b0;

        if (!filt && filt_d)     fall <= 1'b1;
        else if (bus.flag_clr[i]) fall <= 1'b0;
      end
    end

    assign bus.data_from_gpio[i] = filt;
    assign bus.rise_flag[i]      = rise;
    assign bus.fall_flag[i]      = fall;
  end

endmodule

// File: tb/tb_gpio_bidir_filt.sv
// Directed test of gpio_bidir_filt.
// Covers muxed input latency, glitch filtering, open-drain drive, out-of-range selects, flag priority and async reset.
module tb_gpio_bidir_filt;
  localparam int IOW = 36;
  localparam int PNW = 8;
  localparam int FW  = 4;

  logic           clk;
  logic           reset_n;
  logic [IOW-1:0] drv_en;
  logic [IOW-1:0] drv_val;
  wire  [IOW-1:0] gpioport;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_bidir_filt_if #(.IOWidth(IOW), .PortNumWidth(PNW), .FiltWidth(FW)) bus ();

  gpio_bidir_filt #(
    .IOWidth(IOW), .PortNumWidth(PNW), .Mux_En(1), .FiltWidth(FW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .gpioport (gpioport)
  );

  for (genvar k = 0; k < IOW; k++) begin : g_drv
    assign gpioport[k] = drv_en[k] ? drv_val[k] : 1'bz;
  end

  // Pin 1 is never driven by the bench; a released pin reads back as 1.
  pullup pu1 (gpioport[1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    drv_en       = '1;
    drv_en[1]    = 1'b0;
    drv_en[3]    = 1'b0;
    drv_val      = '0;
    drv_val[6]   = 1'b1;
    for (int i = 0; i < IOW; i++) bus.portselnum[i] = PNW'(i);
    bus.portselnum[0] = 8'd5;
    bus.portselnum[3] = 8'd200;
    bus.out_ena    = '0;
    bus.out_ena[3] = 1'b1;
    bus.od         = '0;
    bus.out_data   = '0;
    bus.filt_ena   = '0;
    bus.filt_len   = '0;
    bus.flag_clr   = '0;

    // Reset state
    #12;
    check("rst_data", 64'(bus.data_from_gpio), 64'd0);
    check("rst_rise", 64'(bus.rise_flag), 64'd0);
    check("rst_fall", 64'(bus.fall_flag), 64'd0);
    check("rst_pin3_drv0", 64'(gpioport[3]), 64'd0);
    check("rst_pin1_z", 64'(gpioport[1]), 64'd1);

    // Release with pin 6 held high
    tick(1);
    reset_n = 1'b1;
    tick(3);
    check("rel_data6", 64'(bus.data_from_gpio[6]), 64'd1);
    check("rel_rise6_early", 64'(bus.rise_flag[6]), 64'd0);
    check("rel_data0", 64'(bus.data_from_gpio[0]), 64'd0);
    tick(1);
    check("rel_rise6", 64'(bus.rise_flag[6]), 64'd1);
    bus.flag_clr = '1;
    tick(1);
    bus.flag_clr = '0;
    check("clr_all_rise", 64'(bus.rise_flag), 64'd0);

    // Channel 0 routed from pin 5, bypass latency
    drv_val[5] = 1'b1;
    tick(2);
    check("mux_data0_e2", 64'(bus.data_from_gpio[0]), 64'd0);
    tick(1);
    check("mux_data0_e3", 64'(bus.data_from_gpio[0]), 64'd1);
    check("mux_data5_e3", 64'(bus.data_from_gpio[5]), 64'd1);
    check("mux_rise0_e3", 64'(bus.rise_flag[0]), 64'd0);
    tick(1);
    check("mux_rise0_e4", 64'(bus.rise_flag[0]), 64'd1);
    check("mux_rise5_e4", 64'(bus.rise_flag[5]), 64'd1);

    // Glitch filter, N=4, on channel 2
    bus.filt_ena[2] = 1'b1;
    bus.filt_len    = 4'd4;
    tick(1);
    drv_val[2] = 1'b1;
    tick(3);
    drv_val[2] = 1'b0;
    tick(8);
    check("filt_reject3", 64'(bus.data_from_gpio[2]), 64'd0);
    drv_val[2] = 1'b1;
    tick(5);
    check("filt_4_e5", 64'(bus.data_from_gpio[2]), 64'd0);
    tick(1);
    check("filt_4_e6", 64'(bus.data_from_gpio[2]), 64'd1);
    drv_val[2] = 1'b0;
    tick(8);
    check("filt_fall_done", 64'(bus.data_from_gpio[2]), 64'd0);

    // Async reset mid-count (cnt=2) discards the partial count
    drv_val[2] = 1'b1;
    tick(4);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", 64'(bus.data_from_gpio), 64'd0);
    check("mid_rst_rise", 64'(bus.rise_flag), 64'd0);
    check("mid_rst_fall", 64'(bus.fall_flag), 64'd0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    check("restart_e5", 64'(bus.data_from_gpio[2]), 64'd0);
    tick(1);
    check("restart_e6", 64'(bus.data_from_gpio[2]), 64'd1);

    // Open-drain and push-pull drive on pin 1
    bus.out_ena[1]  = 1'b1;
    bus.od[1]       = 1'b1;
    bus.out_data[1] = 1'b0;
    #1;
    check("od_idle_z", 64'(gpioport[1]), 64'd1);
    bus.out_data[1] = 1'b1;
    #1;
    check("od_before_edge", 64'(gpioport[1]), 64'd1);
    tick(1);
    check("od_drive0", 64'(gpioport[1]), 64'd0);
    bus.out_data[1] = 1'b0;
    tick(1);
    check("od_release_z", 64'(gpioport[1]), 64'd1);
    bus.od[1] = 1'b0;
    #1;
    check("pp_drive0", 64'(gpioport[1]), 64'd0);
    bus.out_data[1] = 1'b1;
    tick(1);
    check("pp_drive1", 64'(gpioport[1]), 64'd1);
    bus.out_data[1] = 1'b0;
    tick(1);
    check("pp_drive0_again", 64'(gpioport[1]), 64'd0);
    bus.out_ena[1] = 1'b0;

    // Out-of-range select on channel 3
    drv_val      = '1;
    bus.out_data = '1;
    tick(4);
    check("oor_pin3", 64'(gpioport[3]), 64'd0);
    check("oor_data3", 64'(bus.data_from_gpio[3]), 64'd0);
    check("ctl_data4", 64'(bus.data_from_gpio[4]), 64'd1);
    check("ctl_rise4", 64'(bus.rise_flag[4]), 64'd1);
    check("ctl_fall4", 64'(bus.fall_flag[4]), 64'd0);

    // Clear coinciding with a new fall event: set wins, rise is cleared
    drv_val[4] = 1'b0;
    tick(3);
    check("fall_data4", 64'(bus.data_from_gpio[4]), 64'd0);
    bus.flag_clr[4] = 1'b1;
    tick(1);
    bus.flag_clr[4] = 1'b0;
    check("clrset_rise4", 64'(bus.rise_flag[4]), 64'd0);
    check("clrset_fall4", 64'(bus.fall_flag[4]), 64'd1);
    bus.flag_clr[4] = 1'b1;
    tick(1);
    bus.flag_clr[4] = 1'b0;
    check("clr_fall4", 64'(bus.fall_flag[4]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_bidir_filt.md
GPIO_BIDIR_FILT -- requirements
Module: gpio_bidir_filt

Interface
- REQ-001: Parameter IOWidth, default 36; number of pins and channels.
- REQ-002: Parameter PortNumWidth, default 8; width of each per-channel pin-select number.
- REQ-003: Parameter Mux_En, default 1; 1 routes channel i through portselnum[i], 0 maps channel i to pin i.
- REQ-004: Parameter FiltWidth, default 4; width of the glitch-filter length and of each per-channel counter.
- REQ-005: The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
  - clk  input  1  sole clock; all registers update on its rising edge.
  - reset_n  input  1  asynchronous, active-low reset.
  - portselnum  input  PortNumWidth x IOWidth  per-channel pin select (unpacked array).
  - out_ena  input  IOWidth  per-pin output enable (combinational to pin).
  - od  input  IOWidth  per-pin open-drain mode.
  - out_data  input  IOWidth  output data before muxing.
  - filt_ena  input  IOWidth  per-channel input filter enable.
  - filt_len  input  FiltWidth  global filter length, in clocks.
  - flag_clr  input  IOWidth  per-channel single-cycle clear of the edge flags.
  - gpioport  inout  IOWidth  device pins.
  - data_from_gpio  output  IOWidth  synchronised, filtered input data.
  - rise_flag  output  IOWidth  sticky rising-edge flag.
  - fall_flag  output  IOWidth  sticky falling-edge flag.

Function
- REQ-006: Select rule: with Mux_En=1, sel(i)=portselnum[i]; with Mux_En=0, sel(i)=i.
- REQ-007: Out-of-range select (sel(i) >= IOWidth) SHALL yield 0 on both the input and output mux paths.
- REQ-008: Output register: omux[i] <= out_data[sel(i)] on every clk edge.
- REQ-009: Pin drive, combinational from omux, od and out_ena:
  - out_ena[i]=0: gpioport[i]=Z.
  - od[i]=1: gpioport[i]=0 when omux[i]=1, else Z.
  - od[i]=0: gpioport[i]=omux[i].
- REQ-010: Input path: s1[i] <= gpioport[sel(i)]; s2[i] <= s1[i]; data_from_gpio[i]=filt[i], where filt[i] is a register.
- REQ-011: Filter bypass: when filt_ena[i]=0, or filt_len is 0 or 1, filt[i] <= s2[i] every clock.
  - Pin-to-output latency in bypass is 3 clk edges.
- REQ-012: Filter counting: when enabled with filt_len=N>=2, cnt[i] increments on each edge where s2[i]!=filt[i].
- REQ-013: Filter update: on the edge where a mismatch occurs with cnt[i]==N-1, filt[i] <= s2[i] and cnt[i] <= 0.
  - Latency is therefore 2+N edges.
- REQ-014: Filter restart: any edge with s2[i]==filt[i] SHALL clear cnt[i] to 0.
  - Pulses shorter than N clocks at s2 are rejected.
- REQ-015: Counter width: cnt[i] SHALL never exceed N-1 and SHALL never wrap.
- REQ-016: Live filt_len change: cnt[i] >= new N-1 with a mismatch SHALL cause an update on the next edge.
- REQ-017: Live filt_ena change: clearing filt_ena[i] SHALL clear cnt[i] on the next edge.
- REQ-018: Edge detect: filt[i] transition 0->1 SHALL set rise_flag[i]; transition 1->0 SHALL set fall_flag[i].
  - Both flags are registered and set on the edge after the filt change.
- REQ-019: Flag clear: flag_clr[i]=1 SHALL clear both flags on the next edge.
- REQ-020: Simultaneous set and flag_clr on the same edge: the set SHALL win.
- REQ-021: Channels SHALL be fully independent.
  - Multiple channels selecting the same pin each see identical, independent filter and flag state.

Reset
- REQ-022: Asserting reset_n=0 SHALL clear omux, s1, s2, filt, cnt, rise_flag and fall_flag to 0 immediately, regardless of clk.
- REQ-023: During reset, the pins SHALL follow REQ-009 with omux=0: driven 0 where out_ena=1 and od=0, otherwise Z.
- REQ-024: Reset asserted mid-filter SHALL discard the partial count.
- REQ-025: Reset release: a pin held high SHALL produce filt=1 and set rise_flag per REQ-011 to REQ-018. This is defined behaviour.

Verification
- REQ-026: Mux_En=1, portselnum[0]=5, filt_ena=0: pin5 0->1 -> data_from_gpio[0]=1 on edge 3; rise_flag[0]=1 on edge 4.
- REQ-027: filt_ena[2]=1, filt_len=4: a 3-clock high pulse at s2 -> data_from_gpio[2] stays 0; a 4-clock high -> data_from_gpio[2] goes 1 at 2+4 edges after the pin change.
- REQ-028: od[1]=1, out_ena[1]=1: out_data=1 -> pin1=0 one edge later; out_data=0 -> pin1=Z. Repeat with od[1]=0 -> pin1 follows out_data.
- REQ-029: portselnum[3]=200 with IOWidth=36 -> data_from_gpio[3]=0 and omux[3]=0, whatever the pin and out_data values.
- REQ-030: rise_flag[4] set and flag_clr[4] pulsed on the same edge as a new fall event -> rise_flag[4]=0, fall_flag[4]=1.
- REQ-031: reset_n pulsed low between clock edges while cnt=2 -> all outputs 0 at once; after release, filtering restarts from cnt=0.
